// File: rtl/store_commit_writer.sv
// store_commit_writer
// Memory-side responder for ROB store commits. Committed stores are queued
// and each one is serialised into little-endian byte writes on the shared
// 8-bit RAM/IO bus once the memory arbiter grants access. Only rst discards
// queued stores; a mispredict flush has no effect here.
module store_commit_writer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rob_write_mem,
    input  logic [1:0]       rob_mem_size,
    input  logic [31:0]      rob_mem_addr,
    input  logic [31:0]      rob_mem_value,
    output logic             store_full,
    output logic             store_empty,
    output logic [PTR_W:0]   store_pending,
    output logic             mem_req,
    input  logic             mem_grant,
    output logic [31:0]      mem_a,
    output logic [7:0]       mem_dout,
    output logic             mem_wr,
    input  logic             io_buffer_full,
    output logic             store_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WRITE   = 2'd2,
        WAIT_IO = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       k;
    logic [1:0]       k_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;

    // Store queue payload; no reset needed, validity is tracked by count.
    logic [1:0]       q_size  [DEPTH];
    logic [31:0]      q_addr  [DEPTH];
    logic [31:0]      q_value [DEPTH];

    logic             push;
    logic             pop;
    logic [1:0]       head_size;
    logic [31:0]      head_addr;
    logic [31:0]      head_value;
    logic [31:0]      byte_addr;
    logic [7:0]       byte_data;
    logic             io_hit;

    // Index of the final byte of a store: sizes 2 and 3 are both words.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] size);
        case (size)
            2'd0:    last_byte_idx = 2'd0;
            2'd1:    last_byte_idx = 2'd1;
            default: last_byte_idx = 2'd3;
        endcase
    endfunction

    // Select byte k of a little-endian value.
    function automatic logic [7:0] select_byte(input logic [31:0] value, input logic [1:0] idx);
        select_byte = value[{idx, 3'b000} +: 8];
    endfunction

    assign push          = rdy & rob_write_mem & ~store_full;
    assign store_full    = (count == (PTR_W+1)'(DEPTH));
    assign store_empty   = (count == '0) && (state == IDLE);
    assign store_pending = count;

    assign head_size  = q_size[rd_ptr];
    assign head_addr  = q_addr[rd_ptr];
    assign head_value = q_value[rd_ptr];
    assign byte_addr  = head_addr + {30'd0, k};
    assign byte_data  = select_byte(head_value, k);
    // The UART region is decoded from the byte actually being written.
    assign io_hit     = (byte_addr[17:16] == 2'b11);

    // Queue payload write on an accepted commit.
    always_ff @(posedge clk) begin
        if (push) begin
            q_size[wr_ptr]  <= rob_mem_size;
            q_addr[wr_ptr]  <= rob_mem_addr;
            q_value[wr_ptr] <= rob_mem_value;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM state and byte counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= 2'd0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    // Next-state logic and bus outputs; rdy low freezes everything.
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        mem_req    = 1'b0;
        mem_wr     = 1'b0;
        mem_a      = 32'd0;
        mem_dout   = 8'd0;
        store_done = 1'b0;
        pop        = 1'b0;

        case (state)
            IDLE: begin
                // A commit arriving this cycle is enough to start requesting
                // next cycle, which keeps the push-to-request latency at one.
                if ((count != '0) || push) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_grant) begin
                    state_nxt = WRITE;
                    k_nxt     = 2'd0;
                end
            end
            WRITE: begin
                mem_req  = 1'b1;
                mem_a    = byte_addr;
                mem_dout = byte_data;
                if (io_hit && io_buffer_full) begin
                    state_nxt = WAIT_IO;
                end else begin
                    mem_wr = 1'b1;
                    if (k == last_byte_idx(head_size)) begin
                        pop        = 1'b1;
                        store_done = 1'b1;
                        state_nxt  = IDLE;
                        k_nxt      = 2'd0;
                    end else begin
                        k_nxt = k + 2'd1;
                    end
                end
            end
            WAIT_IO: begin
                mem_req = 1'b1;
                if (!io_buffer_full) begin
                    state_nxt = WRITE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!rdy) begin
            state_nxt  = state;
            k_nxt      = k;
            mem_wr     = 1'b0;
            store_done = 1'b0;
            pop        = 1'b0;
        end
    end

endmodule

// File: tb/tb_store_commit_writer.sv
// Bench for store_commit_writer: directed timing scenarios followed by a
// randomized phase, all checked against a byte-level reference queue.
module tb_store_commit_writer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rob_write_mem;
    logic [1:0]  rob_mem_size;
    logic [31:0] rob_mem_addr;
    logic [31:0] rob_mem_value;
    logic        store_full;
    logic        store_empty;
    logic [2:0]  store_pending;
    logic        mem_req;
    logic        mem_grant;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        store_done;

    store_commit_writer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rob_write_mem  (rob_write_mem),
        .rob_mem_size   (rob_mem_size),
        .rob_mem_addr   (rob_mem_addr),
        .rob_mem_value  (rob_mem_value),
        .store_full     (store_full),
        .store_empty    (store_empty),
        .store_pending  (store_pending),
        .mem_req        (mem_req),
        .mem_grant      (mem_grant),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .store_done     (store_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        bit          last;
    } exp_byte_t;

    exp_byte_t exp_q[$];
    int        n_stores = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int nbytes_of(input logic [1:0] size);
        if (size == 2'd0) return 1;
        if (size == 2'd1) return 2;
        return 4;
    endfunction

    // Reference model: every accepted store becomes its bytes in address order,
    // and the bus must reproduce exactly that byte stream.
    always @(negedge clk) begin
        if (mon_en) begin
            check("pending", 32'(store_pending), 32'(n_stores));
            check("full", 32'(store_full), 32'(n_stores == 4));
            if (store_empty) check("empty_cnt", 32'(n_stores), 32'd0);
            if (!rdy) begin
                check("rdy0_wr", 32'(mem_wr), 32'd0);
                check("rdy0_done", 32'(store_done), 32'd0);
            end
            if (rob_write_mem && rdy && store_full)
                check("push_while_full", 32'd1, 32'd0);
            if (mem_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr", 32'(mem_wr), 32'd0);
                end else begin
                    exp_byte_t e;
                    e = exp_q.pop_front();
                    check("byte_addr", mem_a, e.a);
                    check("byte_data", 32'(mem_dout), 32'(e.d));
                    check("done_on_last", 32'(store_done), 32'(e.last));
                end
            end else if (store_done) begin
                check("done_without_wr", 32'(store_done), 32'd0);
            end
            if (store_done && n_stores > 0) n_stores--;
            if (rst) begin
                exp_q.delete();
                n_stores = 0;
            end else if (rdy && rob_write_mem && !store_full) begin
                int nb;
                nb = nbytes_of(rob_mem_size);
                for (int i = 0; i < nb; i++)
                    exp_q.push_back('{rob_mem_addr + 32'(i), rob_mem_value[8*i +: 8], (i == nb - 1)});
                n_stores++;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] val);
        rob_write_mem = 1'b1;
        rob_mem_size  = size;
        rob_mem_addr  = addr;
        rob_mem_value = val;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            next_cycle();
            @(negedge clk);
            if (store_empty) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bit seen;
        rst = 1'b1; rdy = 1'b1; rob_write_mem = 1'b0; rob_mem_size = 2'd0;
        rob_mem_addr = 32'd0; rob_mem_value = 32'd0; mem_grant = 1'b1; io_buffer_full = 1'b0;
        next_cycle();
        mon_en = 1'b1;
        next_cycle();
        @(negedge clk);
        check("rst_full", 32'(store_full), 32'd0);
        check("rst_empty", 32'(store_empty), 32'd1);
        check("rst_pending", 32'(store_pending), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_a", mem_a, 32'd0);
        check("rst_dout", 32'(mem_dout), 32'd0);
        check("rst_wr", 32'(mem_wr), 32'd0);
        check("rst_done", 32'(store_done), 32'd0);
        next_cycle();
        rst = 1'b0;

        // 1: word store latency and byte order
        next_cycle();
        drive_store(2'd2, 32'h100, 32'hDEADBEEF);
        next_cycle();
        rob_write_mem = 1'b0;
        @(negedge clk);
        check("t1_req", 32'(mem_req), 32'd1);
        check("t1_nowr", 32'(mem_wr), 32'd0);
        w = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            check("t1_wr", 32'(mem_wr), 32'd1);
            check("t1_a", mem_a, 32'h100 + 32'(i));
            check("t1_d", 32'(mem_dout), 32'(w[7:0]));
            check("t1_done", 32'(store_done), 32'(i == 3));
            w = w >> 8;
        end
        next_cycle();
        @(negedge clk);
        check("t1_idle_req", 32'(mem_req), 32'd0);

        // 2: byte then misaligned half, order kept
        next_cycle();
        drive_store(2'd0, 32'h20, 32'h12345678);
        next_cycle();
        drive_store(2'd1, 32'h41, 32'hAAAA5566);
        next_cycle();
        rob_write_mem = 1'b0;
        wait_idle(40);
        check("t2_drained", 32'(exp_q.size()), 32'd0);

        // 3: fill queue without grant
        mem_grant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(2'(i), 32'h1000 + 32'(16 * i), $urandom);
            next_cycle();
        end
        rob_write_mem = 1'b0;
        @(negedge clk);
        check("t3_full", 32'(store_full), 32'd1);
        check("t3_pending", 32'(store_pending), 32'd4);
        check("t3_req", 32'(mem_req), 32'd1);
        next_cycle();
        mem_grant = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (store_done) begin
                seen = 1'b1;
                break;
            end
            next_cycle();
        end
        check("t3_done_seen", 32'(seen), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t3_full_clr", 32'(store_full), 32'd0);
        check("t3_pending3", 32'(store_pending), 32'd3);
        wait_idle(80);

        // 4: IO stall
        next_cycle();
        io_buffer_full = 1'b1;
        drive_store(2'd0, 32'h30000, 32'h000000A5);
        next_cycle();
        rob_write_mem = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("t4_req", 32'(mem_req), 32'd1);
            if (c >= 2) check("t4_nowr", 32'(mem_wr), 32'd0);
            next_cycle();
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("t4_clear_nowr", 32'(mem_wr), 32'd0);
        check("t4_clear_req", 32'(mem_req), 32'd1);
        next_cycle();
        @(negedge clk);
        check("t4_wr", 32'(mem_wr), 32'd1);
        check("t4_a", mem_a, 32'h30000);
        wait_idle(20);

        // 5: reset during second byte of a word store
        next_cycle();
        drive_store(2'd2, 32'h200, 32'h11223344);
        next_cycle();
        rob_write_mem = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("t5_byte1_a", mem_a, 32'h201);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t5_wr", 32'(mem_wr), 32'd0);
        check("t5_empty", 32'(store_empty), 32'd1);
        check("t5_pending", 32'(store_pending), 32'd0);
        check("t5_req", 32'(mem_req), 32'd0);

        // 6: rdy low mid-store
        next_cycle();
        drive_store(2'd2, 32'h300, 32'hCAFEF00D);
        next_cycle();
        rob_write_mem = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_frozen_wr", 32'(mem_wr), 32'd0);
            check("t6_frozen_done", 32'(store_done), 32'd0);
            next_cycle();
        end
        rdy = 1'b1;
        @(negedge clk);
        check("t6_resume_wr", 32'(mem_wr), 32'd1);
        check("t6_resume_a", mem_a, 32'h302);
        check("t6_resume_d", 32'(mem_dout), 32'hFE);
        wait_idle(20);

        // Randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            next_cycle();
            rst = ($urandom_range(0, 399) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            if (!(mem_req && mem_grant)) mem_grant = ($urandom_range(0, 2) != 0);
            io_buffer_full = ($urandom_range(0, 3) == 0);
            if (!store_full && $urandom_range(0, 4) < 2) begin
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w[17:16] = 2'b11;
                drive_store(2'($urandom_range(0, 3)), w, $urandom);
            end else begin
                rob_write_mem = 1'b0;
            end
        end
        rst = 1'b0; rdy = 1'b1; mem_grant = 1'b1; io_buffer_full = 1'b0; rob_write_mem = 1'b0;
        wait_idle(200);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_stores", 32'(n_stores), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
